// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch stage: op classes, opcodes, FSM states,
// RS routing, plus the opcode classifier used by decode and ImmGen.
package dispatch_pkg;

  typedef enum logic [2:0] {
    ALU_I   = 3'd0,
    ALU_R   = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    JALR    = 3'd5,
    ILLEGAL = 3'd7
  } op_class_e;

  localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  typedef enum logic {
    RT_ALU = 1'b0,
    RT_LSU = 1'b1
  } route_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_ALU_I:  return ALU_I;
      OPC_ALU_R:  return ALU_R;
      OPC_LOAD:   return LOAD;
      OPC_STORE:  return STORE;
      OPC_BRANCH: return BRANCH;
      OPC_JALR:   return JALR;
      default:    return ILLEGAL;
    endcase
  endfunction

  function automatic route_e route_of(input op_class_e cls);
    return (cls == LOAD || cls == STORE) ? RT_LSU : RT_ALU;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_immgen.sv
// ImmGen: purely combinational sign-extended immediate for the decoded
// instruction format (I, S, B); R-type and illegal opcodes yield zero.
module dispatch_immgen
  import dispatch_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  // Bits [19:12] (rs1/funct3) never contribute to an immediate.
  logic unused_fields;
  assign unused_fields = ^instr_i[19:12];

  // Select the immediate layout from the opcode class.
  always_comb begin
    imm_o = '0;
    case (classify(instr_i[6:0]))
      ALU_I, LOAD, JALR: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      STORE:             imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      BRANCH:            imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8], 1'b0};
      default:           imm_o = '0;
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-entry decode/dispatch stage: classifies the fetched instruction,
// allocates a ROB tag and offers a registered packet to the ALU or LSU RS.
// Optional macro DISPATCH_PERF_EN adds perf_disp / perf_stall counters.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             rob_ready,
  input  logic [TAG_W-1:0] rob_tag,
  output logic             rob_alloc,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             lsu_valid,
  input  logic             lsu_ready,
  output logic [2:0]       d_class,
  output logic [4:0]       d_rd,
  output logic [4:0]       d_rs1,
  output logic [4:0]       d_rs2,
  output logic             d_use_rs1,
  output logic             d_use_rs2,
  output logic             d_wr_rd,
  output logic [2:0]       d_funct3,
  output logic             d_f7b5,
  output logic [XLEN-1:0]  d_imm,
  output logic [XLEN-1:0]  d_pc,
  output logic [TAG_W-1:0] d_tag,
  output logic             illegal_o
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]      perf_disp,
  output logic [31:0]      perf_stall
`endif
);

  state_e     state_q, state_d;
  op_class_e  class_q;
  route_e     route_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic       use_rs1_q, use_rs2_q, wr_rd_q, f7b5_q;
  logic [2:0] funct3_q;
  logic [XLEN-1:0]  imm_q, pc_q;
  logic [TAG_W-1:0] tag_q;

  logic       accept, out_fire;
  op_class_e  in_class;
  logic [31:0] in_imm;

  assign in_class = classify(in_instr[6:0]);

  dispatch_immgen u_immgen (
    .instr_i (in_instr),
    .imm_o   (in_imm)
  );

  // Handshakes, RS offers and next state; flush wins over accept and drain.
  always_comb begin
    state_d   = state_q;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    illegal_o = 1'b0;
    out_fire  = 1'b0;
    in_ready  = 1'b0;
    accept    = 1'b0;
    if (state_q == ST_FULL) begin
      alu_valid = (route_q == RT_ALU);
      lsu_valid = (route_q == RT_LSU);
    end
    illegal_o = (state_q == ST_TRAP);
    out_fire  = (alu_valid && alu_ready) || (lsu_valid && lsu_ready);
    in_ready  = rob_ready && !flush_i &&
                ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_fire));
    accept    = in_valid && in_ready;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = (in_class == ILLEGAL) ? ST_TRAP : ST_FULL;
    end else if ((state_q == ST_FULL) && out_fire) begin
      state_d = ST_EMPTY;
    end
  end

  assign rob_alloc = accept;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Packet capture on accept; fields stay stable while the packet is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q   <= ALU_I;
      route_q   <= RT_ALU;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      wr_rd_q   <= 1'b0;
      funct3_q  <= '0;
      f7b5_q    <= 1'b0;
      imm_q     <= '0;
      pc_q      <= '0;
      tag_q     <= '0;
    end else if (accept) begin
      class_q   <= in_class;
      route_q   <= route_of(in_class);
      rd_q      <= in_instr[11:7];
      rs1_q     <= in_instr[19:15];
      rs2_q     <= in_instr[24:20];
      use_rs1_q <= (in_class != ILLEGAL);
      use_rs2_q <= (in_class == ALU_R) || (in_class == STORE) || (in_class == BRANCH);
      wr_rd_q   <= (in_class != STORE) && (in_class != BRANCH) && (in_instr[11:7] != 5'd0);
      funct3_q  <= in_instr[14:12];
      f7b5_q    <= in_instr[30];
      imm_q     <= in_imm;
      pc_q      <= in_pc;
      tag_q     <= rob_tag;
    end
  end

  assign d_class   = class_q;
  assign d_rd      = rd_q;
  assign d_rs1     = rs1_q;
  assign d_rs2     = rs2_q;
  assign d_use_rs1 = use_rs1_q;
  assign d_use_rs2 = use_rs2_q;
  assign d_wr_rd   = wr_rd_q;
  assign d_funct3  = funct3_q;
  assign d_f7b5    = f7b5_q;
  assign d_imm     = imm_q;
  assign d_pc      = pc_q;
  assign d_tag     = tag_q;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp_q, perf_stall_q;

  // Dispatch and stall counters; they survive flush and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_fire)                          perf_disp_q  <= perf_disp_q + 32'd1;
      if ((state_q == ST_FULL) && !out_fire) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_disp  = perf_disp_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural packet model.
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        rob_ready, rob_alloc;
  logic [3:0]  rob_tag;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [2:0]  d_class, d_funct3;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic        d_use_rs1, d_use_rs2, d_wr_rd, d_f7b5, illegal_o;
  logic [31:0] d_imm, d_pc;
  logic [3:0]  d_tag;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp, perf_stall;
`endif

  always #5 clk = ~clk;

  dispatch_ctrl #(.TAG_W(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rob_ready(rob_ready), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .d_class(d_class), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_wr_rd(d_wr_rd),
    .d_funct3(d_funct3), .d_f7b5(d_f7b5), .d_imm(d_imm), .d_pc(d_pc),
    .d_tag(d_tag), .illegal_o(illegal_o)
`ifdef DISPATCH_PERF_EN
    , .perf_disp(perf_disp), .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic        ur1, ur2, wr, f7;
    logic [2:0]  f3;
    logic [31:0] imm, pc;
    logic [3:0]  tag;
    bit          lsu;
  } pkt_t;

  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  bit   m_held, m_trap;
  pkt_t m_pkt;
  int   m_disp, m_stall;
  int   alloc_cnt;
  logic [3:0] disp_tags[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode straight from the instruction-set rules using integer arithmetic.
  function automatic pkt_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [3:0] tag);
    pkt_t p;
    int   v;
    case (ins[6:0])
      7'h13:   p.cls = 3'd0;
      7'h33:   p.cls = 3'd1;
      7'h03:   p.cls = 3'd2;
      7'h23:   p.cls = 3'd3;
      7'h63:   p.cls = 3'd4;
      7'h67:   p.cls = 3'd5;
      default: p.cls = 3'd7;
    endcase
    case (p.cls)
      3'd0, 3'd2, 3'd5: v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
      3'd3:             v = int'(ins[11:7]) + int'(ins[30:25]) * 32 - (ins[31] ? 2048 : 0);
      3'd4:             v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 +
                            (ins[7] ? 2048 : 0) - (ins[31] ? 4096 : 0);
      default:          v = 0;
    endcase
    p.imm = 32'(v);
    p.rd  = ins[11:7];
    p.rs1 = ins[19:15];
    p.rs2 = ins[24:20];
    p.f3  = ins[14:12];
    p.f7  = ins[30];
    p.ur1 = (p.cls != 3'd7);
    p.ur2 = (p.cls == 3'd1) || (p.cls == 3'd3) || (p.cls == 3'd4);
    p.wr  = (p.cls != 3'd3) && (p.cls != 3'd4) && (p.rd != 5'd0);
    p.lsu = (p.cls == 3'd2) || (p.cls == 3'd3);
    p.pc  = pc;
    p.tag = tag;
    return p;
  endfunction

  function automatic bit model_fire();
    return m_held && (m_pkt.lsu ? lsu_ready : alu_ready);
  endfunction

  function automatic bit model_in_ready();
    return rob_ready && !flush_i && !m_trap && (!m_held || model_fire());
  endfunction

  task automatic model_reset();
    m_held = 0; m_trap = 0; m_disp = 0; m_stall = 0;
  endtask

  task automatic check_outputs();
    bit er;
    er = model_in_ready();
    chk("in_ready",  in_ready,  er);
    chk("rob_alloc", rob_alloc, in_valid && er);
    chk("alu_valid", alu_valid, m_held && !m_pkt.lsu);
    chk("lsu_valid", lsu_valid, m_held && m_pkt.lsu);
    chk("illegal_o", illegal_o, m_trap);
    if (m_held) begin
      chk("d_class",   d_class,   m_pkt.cls);
      chk("d_rd",      d_rd,      m_pkt.rd);
      chk("d_rs1",     d_rs1,     m_pkt.rs1);
      chk("d_rs2",     d_rs2,     m_pkt.rs2);
      chk("d_use_rs1", d_use_rs1, m_pkt.ur1);
      chk("d_use_rs2", d_use_rs2, m_pkt.ur2);
      chk("d_wr_rd",   d_wr_rd,   m_pkt.wr);
      chk("d_funct3",  d_funct3,  m_pkt.f3);
      chk("d_f7b5",    d_f7b5,    m_pkt.f7);
      chk("d_imm",     d_imm,     m_pkt.imm);
      chk("d_pc",      d_pc,      m_pkt.pc);
      chk("d_tag",     d_tag,     m_pkt.tag);
    end
`ifdef DISPATCH_PERF_EN
    chk("perf_disp",  perf_disp,  32'(m_disp));
    chk("perf_stall", perf_stall, 32'(m_stall));
`endif
  endtask

  task automatic model_step();
    bit fire, acc;
    pkt_t p;
    fire = model_fire();
    acc  = in_valid && model_in_ready();
    if (fire) m_disp++;
    if (m_held && !fire) m_stall++;
    if (flush_i) begin
      m_held = 0; m_trap = 0;
    end else if (acc) begin
      p = model_decode(in_instr, in_pc, rob_tag);
      m_pkt  = p;
      m_trap = (p.cls == 3'd7);
      m_held = !m_trap;
    end else if (fire) begin
      m_held = 0;
    end
  endtask

  // One clock: check settled outputs, observe handshakes, advance the model.
  task automatic tick();
    #1;
    check_outputs();
    if (rob_alloc === 1'b1) alloc_cnt++;
    if (alu_valid === 1'b1 && alu_ready) disp_tags.push_back(d_tag);
    model_step();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] tag);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; rob_tag = tag;
  endtask

  logic [6:0] opc_tab [0:6];

  initial begin
    opc_tab[0] = 7'h13; opc_tab[1] = 7'h33; opc_tab[2] = 7'h03; opc_tab[3] = 7'h23;
    opc_tab[4] = 7'h63; opc_tab[5] = 7'h67; opc_tab[6] = 7'h7F;
    rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rob_ready = 1'b0; rob_tag = '0; alu_ready = 1'b0; lsu_ready = 1'b0;
    model_reset();
    alloc_cnt = 0;

    // Reset state: everything low.
    #3;
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_alu_valid", alu_valid, 1'b0);
    chk("rst_lsu_valid", lsu_valid, 1'b0);
    chk("rst_illegal",   illegal_o, 1'b0);
    chk("rst_d_imm",     d_imm,     32'h0);
    chk("rst_d_pc",      d_pc,      32'h0);
    chk("rst_d_tag",     d_tag,     4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rob_ready = 1'b1;

    // addi x5,x1,-3 to the ALU.
    alu_ready = 1'b1; lsu_ready = 1'b1;
    offer(32'hFFD08293, 32'h0000_0100, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("addi_alu_valid", alu_valid, 1'b1);
    chk("addi_class",     d_class,   3'd0);
    chk("addi_imm",       d_imm,     32'hFFFF_FFFD);
    chk("addi_rd",        d_rd,      5'd5);
    chk("addi_wr_rd",     d_wr_rd,   1'b1);
    chk("addi_use_rs2",   d_use_rs2, 1'b0);
    tick();

    // sw x2,8(x3) stalled three cycles on the LSU, a second instr waiting.
    lsu_ready = 1'b0;
    offer(32'h0021A423, 32'h0000_0104, 4'd2);
    tick();
    offer(32'h003100B3, 32'h0000_0108, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold_imm",  d_imm,     32'h8);
      chk("sw_hold_lsuv", lsu_valid, 1'b1);
      tick();
    end
    lsu_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    // Four back-to-back adds with tags 0..3.
    alloc_cnt = 0;
    disp_tags.delete();
    for (int i = 0; i < 4; i++) begin
      offer(32'h003100B3, 32'h0000_0200 + 32'(i * 4), 4'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("stream_allocs", 32'(alloc_cnt), 32'd4);
    chk("stream_disp_n", 32'(disp_tags.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < disp_tags.size()) chk("stream_tag", disp_tags[i], 4'(i));

    // Illegal opcode traps until flush.
    offer(32'h0000007F, 32'h0000_0300, 4'd5);
    tick();
    offer(32'h003100B3, 32'h0000_0304, 4'd6);
    for (int i = 0; i < 3; i++) begin
      chk("trap_illegal", illegal_o, 1'b1);
      chk("trap_ready",   in_ready,  1'b0);
      tick();
    end
    in_valid = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("post_flush_ready",   in_ready,  1'b1);
    chk("post_flush_illegal", illegal_o, 1'b0);
    @(negedge clk);

    // beq -4 blocked by rob_ready=0, then accepted.
    rob_ready = 1'b0;
    offer(32'hFE000EE3, 32'h0000_0400, 4'd7);
    tick();
    tick();
    rob_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("beq_imm",   d_imm,     32'hFFFF_FFFC);
    chk("beq_wr_rd", d_wr_rd,   1'b0);
    chk("beq_alu",   alu_valid, 1'b1);
    tick();

    // Flush while stalled, then async reset pulse mid-stall.
    alu_ready = 1'b0;
    offer(32'h00500093, 32'h0000_0500, 4'd8);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_alu_valid", alu_valid, 1'b0);
    offer(32'h00812083, 32'h0000_0504, 4'd9);
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_valid", alu_valid, 1'b0);
    chk("arst_lsu_valid", lsu_valid, 1'b0);
    chk("arst_d_tag",     d_tag,     4'h0);
`ifdef DISPATCH_PERF_EN
    chk("arst_perf_stall", perf_stall, 32'h0);
`endif
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = opc_tab[$urandom_range(0, 6)];
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = ins;
      in_pc     = $urandom;
      rob_tag   = 4'($urandom);
      rob_ready = ($urandom_range(0, 3) != 0);
      alu_ready = ($urandom_range(0, 2) != 0);
      lsu_ready = ($urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Single-entry decode/dispatch stage between fetch and the reservation stations (RS) of the OoO core.
- Accepts one instruction per cycle over valid/ready and classifies its opcode.
- Forms the sign-extended immediate, allocates a ROB tag, and routes a registered dispatch packet to the ALU RS or the LSU RS.
- Stalls on RS/ROB back-pressure, traps illegal opcodes and honours pipeline flush.

Parameters:
- TAG_W, 4, ROB tag width.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous squash of the held instruction
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  raw instruction
- in_pc  in  32  instruction PC
- rob_ready  in  1  ROB has a free entry
- rob_tag  in  TAG_W  tag the ROB will assign on alloc
- rob_alloc  out  1  ROB allocation strobe; equals the in_valid&&in_ready handshake
- alu_valid  out  1  packet offered to the ALU RS
- alu_ready  in  1  ALU RS accepts
- lsu_valid  out  1  packet offered to the LSU RS
- lsu_ready  in  1  LSU RS accepts
- d_class  out  3  op class (package enum)
- d_rd / d_rs1 / d_rs2  out  5 each  register indices
- d_use_rs1, d_use_rs2, d_wr_rd  out  1 each  operand-usage flags
- d_funct3  out  3  instr[14:12]
- d_f7b5  out  1  instr[30]
- d_imm  out  32  immediate
- d_pc  out  32  latched PC
- d_tag  out  TAG_W  latched ROB tag
- illegal_o  out  1  unsupported opcode is held

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY.
  - All outputs are 0, except in_ready, which is combinational.
- States:
  - EMPTY: no packet held.
  - FULL: packet held and offered.
  - TRAP: illegal instruction held.
- Opcode classes:
  - 0010011 ALU_I
  - 0110011 ALU_R
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1100111 JALR
  - anything else ILLEGAL
- Immediate rules:
  - I-format (ALU_I/LOAD/JALR): sext instr[31:20].
  - S-format: sext {instr[31:25], instr[11:7]}.
  - B-format: sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - ALU_R and ILLEGAL: 0.
- Usage flags:
  - d_use_rs1 = 1 for all legal classes.
  - d_use_rs2 = 1 for ALU_R, STORE, BRANCH.
  - d_wr_rd = (class not STORE/BRANCH) && rd != 0.
- Routing:
  - LOAD and STORE go to the LSU.
  - All other legal classes go to the ALU.
  - alu_valid = FULL && route==ALU; lsu_valid = FULL && route==LSU.
  - Never both set.
- Output fire: out_fire = (alu_valid && alu_ready) || (lsu_valid && lsu_ready).
- in_ready = rob_ready && !flush_i && (EMPTY || (FULL && out_fire)). This gives full-throughput back-to-back operation; latency is 1 cycle from accept to offer.
- On accept:
  - Capture the decoded fields, in_pc and rob_tag.
  - Next state is FULL, or TRAP if the class is ILLEGAL.
  - On the TRAP transition the ROB entry is still allocated, so the ROB can raise the exception.
- FULL transitions:
  - out_fire without accept goes to EMPTY.
  - out_fire with accept reloads the register.
  - No out_fire: hold; packet fields are stable while valid.
- TRAP:
  - illegal_o=1, in_ready=0, no RS valid.
  - Held until flush_i.
- flush_i:
  - Takes priority over everything; next state is EMPTY.
  - Any RS handshake in the same cycle still completes on the RS side; the packet is then discarded.
  - rob_alloc=0 that cycle.
- rob_ready=0 blocks accept only; a held packet still drains.
- Reset mid-operation: immediate EMPTY; the held packet is lost.

Optional Feature:
- DISPATCH_PERF_EN defined:
  - Adds outputs perf_disp[31:0] (out_fire count) and perf_stall[31:0] (cycles in FULL without out_fire).
  - Both reset to 0, wrap modulo 2^32 and clear on flush_i? No: counters persist across flush.
- Undefined: the ports and counters are absent; the behaviour is otherwise identical.

Decomposition:
- Package dispatch_pkg holds:
  - op_class_e: ALU_I=0, ALU_R=1, LOAD=2, STORE=3, BRANCH=4, JALR=5, ILLEGAL=7.
  - Opcode localparams.
  - state_e.
  - route_e.
- Sub-module: the existing ImmGen is instantiated combinationally on in_instr; its output feeds the capture register.

Test Plan:
- addi x5,x1,-3 (0xFFD08293) with alu_ready=1 → next cycle alu_valid=1, d_class=ALU_I, d_imm=0xFFFFFFFD, d_rd=5, d_wr_rd=1, d_use_rs2=0.
- sw x2,8(x3) (0x0021A423) with lsu_ready=0 for 3 cycles → lsu_valid held 3 cycles with d_imm=8 stable; in_ready=0; drains on cycle 4.
- Stream of 4 back-to-back adds with alu_ready=1 → 4 packets on consecutive cycles; rob_alloc pulsed 4 times; tags match rob_tag sequence 0..3.
- Opcode 0x0000007F → TRAP: illegal_o=1 and in_ready=0 until flush_i; then EMPTY with in_ready=1.
- beq offset -4 (0xFE000EE3) while rob_ready=0 → no accept; after rob_ready=1 → ALU packet with d_imm=0xFFFFFFFC, d_wr_rd=0.
- flush_i while FULL and stalled, plus async rst_n pulse mid-stall → EMPTY, all valids 0; with DISPATCH_PERF_EN, perf_stall counts the stalled cycles.
